// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU register-file and forwarding definitions
package cpu_pkg;
  localparam int REG_ADDR_W = 4;
  localparam int NUM_REGS   = 16;
  localparam int LAT_ALU    = 1;
  localparam int LAT_LOAD   = 3;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [1:0]            fwd_sel_t;

  localparam int FWD_A = 0;
  localparam int FWD_B = 1;
endpackage

// File: rtl/scoreboard_ctrl_if.sv
// rtl/scoreboard_ctrl_if.sv - ID-stage request and EX-stage issue signals of the scoreboard
interface scoreboard_ctrl_if;
  import cpu_pkg::*;

  logic      id_valid;
  reg_addr_t id_sr1;
  reg_addr_t id_sr2;
  reg_addr_t id_dest;
  logic      id_wen;
  logic      id_load;
  logic      flush;
  logic      stall;
  logic      ex_valid;
  fwd_sel_t  ex_forward;
  logic      busy;

  modport master (
    output id_valid, id_sr1, id_sr2, id_dest, id_wen, id_load, flush,
    input  stall, ex_valid, ex_forward, busy
  );

  modport slave (
    input  id_valid, id_sr1, id_sr2, id_dest, id_wen, id_load, flush,
    output stall, ex_valid, ex_forward, busy
  );
endinterface

// File: rtl/scoreboard_cnt.sv
// rtl/scoreboard_cnt.sv - one per-register writeback countdown
module scoreboard_cnt #(
  parameter int LAT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [LAT_W-1:0] load_val,
  output logic [LAT_W-1:0] cnt,
  output logic             ready,
  output logic             fwd
);
  // A new issue to this register replaces whatever was counting down.
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign ready = (cnt == '0);
  assign fwd   = (cnt == LAT_W'(1));
endmodule

// File: rtl/scoreboard_ctrl.sv
// rtl/scoreboard_ctrl.sv - issue-stage hazard scheduler with WB forwarding selects
// Optional SCOREBOARD_STATS_EN adds a saturating stall_cycles counter.
module scoreboard_ctrl
  import cpu_pkg::*;
#(
  parameter int NREGS    = NUM_REGS,
  parameter int RW       = REG_ADDR_W,
  parameter int LAT_W    = 3,
  parameter int ALU_LAT  = LAT_ALU,
  parameter int LOAD_LAT = LAT_LOAD
) (
  input  logic               clk,
  input  logic               rst,
  scoreboard_ctrl_if.slave   bus
`ifdef SCOREBOARD_STATS_EN
  ,
  output logic [31:0]        stall_cycles
`endif
);
  logic [RW-1:0]    sr1, sr2, dest;
  logic [LAT_W-1:0] cnt [NREGS];
  logic [NREGS-1:0] rdy, fw;
  logic [LAT_W-1:0] new_lat;
  logic             haz1, haz2, fwd1, fwd2, waw, active, issue;
  fwd_sel_t         fwd_d;

  assign sr1  = bus.id_sr1;
  assign sr2  = bus.id_sr2;
  assign dest = bus.id_dest;

  assign cnt[0] = '0;
  assign rdy[0] = 1'b1;
  assign fw[0]  = 1'b0;

  for (genvar r = 1; r < NREGS; r++) begin : g_cnt
    scoreboard_cnt #(.LAT_W(LAT_W)) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (issue && bus.id_wen && (dest == RW'(r))),
      .load_val (new_lat),
      .cnt      (cnt[r]),
      .ready    (rdy[r]),
      .fwd      (fw[r])
    );
  end

  assign new_lat = bus.id_load ? LAT_W'(LOAD_LAT) : LAT_W'(ALU_LAT);

  // Decisions use pre-update counts, so an instruction never sees its own dest.
  assign haz1   = !rdy[sr1] && !fw[sr1];
  assign haz2   = !rdy[sr2] && !fw[sr2];
  assign fwd1   = fw[sr1];
  assign fwd2   = fw[sr2];
  assign waw    = bus.id_wen && (dest != '0) && (cnt[dest] > new_lat);
  assign active = bus.id_valid && !bus.flush;

  assign bus.stall = active && (haz1 || haz2 || waw);
  assign issue     = active && !bus.stall;
  assign bus.busy  = !(&rdy);

  always_comb begin
    fwd_d        = '0;
    fwd_d[FWD_A] = fwd1;
    fwd_d[FWD_B] = fwd2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.ex_valid   <= 1'b0;
      bus.ex_forward <= '0;
    end else begin
      bus.ex_valid   <= issue;
      bus.ex_forward <= issue ? fwd_d : '0;
    end
  end

`ifdef SCOREBOARD_STATS_EN
  always_ff @(posedge clk) begin
    if (rst)
      stall_cycles <= '0;
    else if (bus.stall && (stall_cycles != 32'hFFFF_FFFF))
      stall_cycles <= stall_cycles + 32'd1;
  end
`endif
endmodule

// File: tb/tb_scoreboard_ctrl.sv
// tb/tb_scoreboard_ctrl.sv - randomized and directed bench for scoreboard_ctrl against a behavioural model
module tb_scoreboard_ctrl;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  scoreboard_ctrl_if bus();
`ifdef SCOREBOARD_STATS_EN
  logic [31:0] stall_cycles;
`endif

  scoreboard_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus)
`ifdef SCOREBOARD_STATS_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: cycles remaining until each register's pending write reaches WB.
  int  remain [16];
  int  exp_sc;
  logic exp_stall;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit model_busy();
    for (int r = 1; r < 16; r++) if (remain[r] != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_regs();
    check("busy", bus.busy, model_busy());
`ifdef SCOREBOARD_STATS_EN
    check("stall_cycles", stall_cycles, exp_sc);
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int r = 0; r < 16; r++) remain[r] = 0;
    exp_sc = 0;
    check("rst_ex_valid", bus.ex_valid, 1'b0);
    check("rst_ex_forward", bus.ex_forward, 2'b00);
    check("rst_stall", bus.stall, 1'b0);
    check_regs();
  endtask

  // Called #1 after a posedge; returns #1 after the next posedge.
  task automatic step(input bit v, input int s1, input int s2, input int d,
                      input bit wen, input bit ld, input bit fl);
    int  lat;
    bit  hz1, hz2, waw, iss;
    logic [1:0] efwd;
    bus.id_valid = v;
    bus.id_sr1   = reg_addr_t'(s1);
    bus.id_sr2   = reg_addr_t'(s2);
    bus.id_dest  = reg_addr_t'(d);
    bus.id_wen   = wen;
    bus.id_load  = ld;
    bus.flush    = fl;
    #2;
    lat = ld ? 3 : 1;
    // A source is blocked unless its value is already in the file or on WB now.
    hz1 = (s1 != 0) && (remain[s1] > 1);
    hz2 = (s2 != 0) && (remain[s2] > 1);
    waw = wen && (d != 0) && (remain[d] > lat);
    exp_stall = v && !fl && (hz1 || hz2 || waw);
    iss = v && !fl && !exp_stall;
    efwd = 2'b00;
    if (iss) begin
      efwd[0] = (s1 != 0) && (remain[s1] == 1);
      efwd[1] = (s2 != 0) && (remain[s2] == 1);
    end
    check("stall", bus.stall, exp_stall);
    @(posedge clk);
    for (int r = 1; r < 16; r++) if (remain[r] > 0) remain[r]--;
    if (iss && wen && d != 0) remain[d] = lat;
    if (exp_stall && exp_sc != 32'hFFFF_FFFF) exp_sc++;
    #1;
    check("ex_valid", bus.ex_valid, iss);
    check("ex_forward", bus.ex_forward, efwd);
    check_regs();
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bus.id_valid = 0; bus.id_sr1 = 0; bus.id_sr2 = 0; bus.id_dest = 0;
    bus.id_wen = 0; bus.id_load = 0; bus.flush = 0;
    exp_sc = 0;
    for (int r = 0; r < 16; r++) remain[r] = 0;
    #1;
    do_reset();

    // ALU write r3, then ALU read r3: forwarded on A with no stall.
    step(1, 1, 2, 3, 1, 0, 0);
    step(1, 3, 4, 6, 1, 0, 0);
    check("alu_fwd_a", bus.ex_forward, 2'b01);
    idle();

    // Load r5, then use on sr2: two stall cycles, then forwarded on B.
    step(1, 0, 0, 5, 1, 1, 0);
    step(1, 1, 5, 0, 0, 0, 0);
    check("lu_stall1", exp_stall, 1'b1);
    step(1, 1, 5, 0, 0, 0, 0);
    step(1, 1, 5, 0, 0, 0, 0);
    check("lu_fwd_b", bus.ex_forward, 2'b10);
    check("lu_busy_clear", bus.busy, 1'b0);
    idle();

    // WAW: load r7 then ALU write r7.
    step(1, 0, 0, 7, 1, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 2, 7, 1, 0, 0);
    idle();
    idle();

    // Writes to r0 never create pending state.
    step(1, 0, 0, 0, 1, 1, 0);
    step(1, 0, 0, 0, 1, 0, 0);
    check("r0_busy", bus.busy, 1'b0);

    // Flush during a load-use stall.
    step(1, 0, 0, 2, 1, 1, 0);
    step(1, 2, 2, 9, 1, 0, 1);
    step(1, 2, 2, 9, 1, 0, 0);
    step(1, 2, 2, 9, 1, 0, 0);
    check("same_src_fwd", bus.ex_forward, 2'b11);
    idle();

    // Reset in the middle of a stall.
    step(1, 0, 0, 4, 1, 1, 0);
    step(1, 4, 0, 0, 0, 0, 0);
    bus.id_valid = 1; bus.id_sr1 = 4'd4; bus.flush = 0;
    do_reset();
    bus.id_valid = 0;

    // Randomized traffic on a narrow register window to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 2) begin
        do_reset();
      end else begin
        step($urandom_range(0, 9) < 8, $urandom_range(0, 5), $urandom_range(0, 5),
             $urandom_range(0, 5), $urandom_range(0, 3) != 0,
             $urandom_range(0, 9) < 4, $urandom_range(0, 9) == 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/scoreboard_ctrl.md
Name: scoreboard_ctrl

Overview:
- Issue-stage hazard scheduler for the 16-entry CPU register file and its single WB-to-EX forwarding path.
- Tracks cycles remaining until each in-flight destination register is written back.
- Per ID-stage instruction, decides: issue with register-file operands, issue with WB forwarding on sr1/sr2, or stall.
- Registers the forward selects into EX alongside the instruction, so the forwarding mux is driven by this block.

Parameters:
- NREGS, 16, number of architectural registers; r0 is hardwired zero.
- RW, 4, register address width, log2(NREGS).
- LAT_W, 3, width of each per-register pending counter.
- ALU_LAT, 1, cycles from issue until an ALU result is on the WB bus in the dependent instruction's EX cycle.
- LOAD_LAT, 3, same quantity for loads; must be >= ALU_LAT and < 2^LAT_W.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- id_valid  in  1  valid instruction in ID.
- id_sr1  in  RW  source register 1.
- id_sr2  in  RW  source register 2.
- id_dest  in  RW  destination register.
- id_wen  in  1  instruction writes id_dest.
- id_load  in  1  instruction is a load (uses LOAD_LAT, else ALU_LAT).
- flush  in  1  squash the ID instruction (branch taken).
- stall  out  1  hold IF/ID; combinational.
- ex_valid  out  1  registered: an instruction was issued into EX.
- ex_forward  out  2  registered: bit0 forwards WB data to ALU input A (sr1), bit1 to input B (sr2).
- busy  out  1  any pending counter nonzero; combinational from state.

Behaviour:
- State: cnt[r] for r in 1..NREGS-1, LAT_W bits each. cnt[0] is constant 0.
- Per source s with s!=0:
  - cnt[s]==0: ready.
  - cnt[s]==1: forwardable.
  - cnt[s]>=2: hazard.
- Source r0 is never a hazard and never forwarded.
- waw = id_wen && id_dest!=0 && cnt[id_dest] > new_lat, where new_lat = id_load ? LOAD_LAT : ALU_LAT.
- stall = id_valid && !flush && (hazard(sr1) || hazard(sr2) || waw).
- issue = id_valid && !flush && !stall.
- Counter update each cycle:
  - Every nonzero cnt decrements by 1 (saturating at 0).
  - If issue && id_wen && id_dest!=0, cnt[id_dest] <= new_lat. Issue overrides the decrement on the same register.
- EX registers on every clock:
  - ex_valid <= issue.
  - ex_forward <= issue ? {fwd(sr2), fwd(sr1)} : 2'b00.
- flush has priority over stall. The squashed instruction is not issued and does not alter cnt. In-flight counters keep decrementing; already-issued writes still complete.
- Both sources equal and forwardable: ex_forward = 2'b11.
- Zero-latency behaviour: an instruction's own dest never affects its own sources in the same cycle, because comparisons use pre-update cnt.
- Reset (rst=1 at posedge): all cnt<=0, ex_valid<=0, ex_forward<=0. Consequently stall=0 and busy=0 on the next cycle. Reset mid-operation discards all pending state; the CPU flushes in parallel.
- Latency:
  - ALU-to-dependent: 0 stall cycles, forwarded.
  - Load-to-use: LOAD_LAT-1 stall cycles (2 at defaults), then forwarded.

Optional Feature:
- SCOREBOARD_STATS_EN defined: adds output stall_cycles (32 bits).
  - Increments on each cycle with stall=1; saturates at 0xFFFFFFFF.
  - Cleared by rst.
- Undefined: the port and the counter do not exist. All other behaviour is identical.

Decomposition:
- Shared cpu_pkg holds:
  - REG_ADDR_W=4 and NUM_REGS=16.
  - LAT_ALU/LAT_LOAD constants.
  - typedef reg_addr_t (logic [3:0]).
  - typedef fwd_sel_t (logic [1:0]) with named bit positions FWD_A=0, FWD_B=1.
- Natural sub-module: scoreboard_cnt. Holds one per-register counter with load/decrement/ready/forwardable outputs, instantiated NREGS-1 times in a generate loop. Hazard, stall and issue logic stay in the top module.

Test Plan:
- Reset, then ALU write r3 followed by ALU read sr1=r3 -> stall=0 on both; second instruction has ex_valid=1, ex_forward=2'b01.
- Load r5, then an instruction with sr2=r5 -> stall=1 for exactly 2 cycles; issued on 3rd cycle with ex_forward=2'b10; busy=0 one cycle later.
- Load r7, then ALU write r7 (WAW) -> stall while cnt[7]>1 (2 cycles), then issue; cnt[7] reloads to 1.
- Instruction with sr1=sr2=r0 and dest r0 following a write to r0 -> stall=0, ex_forward=2'b00, busy stays 0.
- Load r2, and during the first stall cycle assert flush -> stall=0, ex_valid=0 next cycle; cnt[2] continues 3->2->1->0.
- Assert rst mid-stall (cnt[4]=2) -> next cycle stall=0, busy=0, ex_valid=0, ex_forward=0; with SCOREBOARD_STATS_EN, stall_cycles=0.
